// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller: state encoding and
// overlay text select codes.
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] TXT_NONE = 2'd0;
  localparam logic [1:0] TXT_RULE = 2'd1;
  localparam logic [1:0] TXT_OVER = 2'd2;

  function automatic logic [1:0] text_for(state_t s);
    case (s)
      PLAY:    return TXT_NONE;
      OVER:    return TXT_OVER;
      default: return TXT_RULE;
    endcase
  endfunction

endpackage

// File: rtl/pong_delay_timer.sv
// Inter-ball / game-over delay: loadable down-counter clocked by frame ticks,
// saturating at zero.
module pong_delay_timer #(
  parameter int TIMER_TICKS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMER_TICKS + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMER_TICKS);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (tick && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new game / play / new ball / game over,
// counts balls, and issues score increment/clear pulses to the BCD counter.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       d_inc,
  output logic       d_clr,
  output logic       graph_still,
  output logic       game_over,
  output logic [1:0] balls_left,
  output logic [1:0] text_sel
);

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);

  state_t     state, state_n;
  logic [1:0] balls_n;
  logic       d_inc_n, d_clr_n;
  logic       btn_any, btn_any_q, btn_rise;
  logic       tmr_load, tmr_tick, tmr_expired;

  assign btn_any  = |btn;
  assign btn_rise = btn_any & ~btn_any_q;
  // Frame ticks only matter while a delay is running.
  assign tmr_tick = refr_tick & ((state == NEWBALL) | (state == OVER));

  pong_delay_timer #(
    .TIMER_TICKS(TIMER_TICKS)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_comb begin
    state_n  = state;
    balls_n  = balls_left;
    d_inc_n  = 1'b0;
    d_clr_n  = 1'b0;
    tmr_load = 1'b0;
    case (state)
      NEWGAME: begin
        balls_n = BALLS_INIT;
        if (btn_rise) begin
          state_n = PLAY;
          d_clr_n = 1'b1;
        end
      end
      PLAY: begin
        // A miss wins over a simultaneous hit; the hit is dropped.
        if (miss) begin
          tmr_load = 1'b1;
          if (balls_left == 2'd1) begin
            state_n = OVER;
            balls_n = 2'd0;
          end else begin
            state_n = NEWBALL;
            balls_n = balls_left - 2'd1;
          end
        end else if (hit) begin
          d_inc_n = 1'b1;
        end
      end
      NEWBALL: begin
        if (tmr_expired && btn_any) state_n = PLAY;
      end
      OVER: begin
        if (tmr_expired) begin
          state_n = NEWGAME;
          balls_n = BALLS_INIT;
        end
      end
      default: state_n = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= NEWGAME;
      balls_left  <= BALLS_INIT;
      btn_any_q   <= 1'b0;
      d_inc       <= 1'b0;
      d_clr       <= 1'b0;
      graph_still <= 1'b1;
      game_over   <= 1'b0;
      text_sel    <= TXT_RULE;
    end else begin
      state       <= state_n;
      balls_left  <= balls_n;
      btn_any_q   <= btn_any;
      d_inc       <= d_inc_n;
      d_clr       <= d_clr_n;
      graph_still <= (state_n != PLAY);
      game_over   <= (state_n == OVER);
      text_sel    <= text_for(state_n);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int BALLS_A = 3;
  localparam int TICKS_A = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       refr_tick = 1'b0, hit = 1'b0, miss = 1'b0;
  logic       d_inc, d_clr, graph_still, game_over;
  logic [1:0] balls_left, text_sel;

  logic [1:0] btn_b = 2'b00;
  logic       refr_tick_b = 1'b0, hit_b = 1'b0, miss_b = 1'b0;
  logic       d_inc_b, d_clr_b, graph_still_b, game_over_b;
  logic [1:0] balls_left_b, text_sel_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALLS(BALLS_A), .TIMER_TICKS(TICKS_A)) dut (
    .clk(clk), .reset(reset), .btn(btn), .refr_tick(refr_tick), .hit(hit), .miss(miss),
    .d_inc(d_inc), .d_clr(d_clr), .graph_still(graph_still), .game_over(game_over),
    .balls_left(balls_left), .text_sel(text_sel)
  );

  pong_game_ctrl #(.BALLS(1), .TIMER_TICKS(1)) dut_b (
    .clk(clk), .reset(reset), .btn(btn_b), .refr_tick(refr_tick_b), .hit(hit_b), .miss(miss_b),
    .d_inc(d_inc_b), .d_clr(d_clr_b), .graph_still(graph_still_b), .game_over(game_over_b),
    .balls_left(balls_left_b), .text_sel(text_sel_b)
  );

  // Behavioural model of the game rules for the main instance.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_WAIT = 2, PH_END = 3;
  int m_phase, m_balls, m_wait;
  bit m_prev, m_pressed, m_rise, m_inc, m_clr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_IDLE; m_balls = BALLS_A; m_wait = 0;
      m_prev = 0; m_inc = 0; m_clr = 0;
    end else begin
      m_inc = 0; m_clr = 0;
      m_pressed = (btn != 2'b00);
      m_rise = m_pressed && !m_prev;
      m_prev = m_pressed;
      case (m_phase)
        PH_IDLE: if (m_rise) begin m_phase = PH_RUN; m_clr = 1; end
        PH_RUN: begin
          if (miss) begin
            m_balls = m_balls - 1;
            m_wait = TICKS_A;
            m_phase = (m_balls == 0) ? PH_END : PH_WAIT;
          end else if (hit) m_inc = 1;
        end
        PH_WAIT: begin
          if (m_wait == 0) begin
            if (m_pressed) m_phase = PH_RUN;
          end else if (refr_tick) m_wait = m_wait - 1;
        end
        default: begin
          if (m_wait == 0) begin
            m_phase = PH_IDLE; m_balls = BALLS_A;
          end else if (refr_tick) m_wait = m_wait - 1;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    btn = 0; refr_tick = 0; hit = 0; miss = 0;
    btn_b = 0; refr_tick_b = 0; hit_b = 0; miss_b = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start_game();
    btn = 2'b01; step();
    btn = 2'b00; step();
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      refr_tick = 1'b1; step();
      refr_tick = 1'b0; step();
    end
  endtask

  task automatic lose_and_resume();
    miss = 1'b1; step(); miss = 1'b0;
    btn = 2'b01;
    run_ticks(TICKS_A);
    btn = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({d_inc, d_clr, graph_still, game_over, balls_left, text_sel} !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1}) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", {d_inc, d_clr, graph_still, game_over, balls_left, text_sel}, 8'b0010_1101);
    end
    checks++;
    if ({graph_still_b, balls_left_b, text_sel_b} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL reset_values_b: got %b want %b", {graph_still_b, balls_left_b, text_sel_b}, 5'b10101);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_start();
    apply_reset();
    btn = 2'b01; step(); btn = 2'b00;
    checks++;
    if ({d_clr, graph_still, balls_left, text_sel} !== {1'b1, 1'b0, 2'd3, 2'd0}) begin
      errors++;
      $display("FAIL start: got clr/still/balls/text %b want %b", {d_clr, graph_still, balls_left, text_sel}, 6'b101100);
    end
    step();
    checks++;
    if (d_clr !== 1'b0) begin
      errors++;
      $display("FAIL start_clr_width: d_clr got %b want 0", d_clr);
    end
  endtask

  task automatic test_scoring();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      hit = 1'b1; step(); hit = 1'b0;
      checks++;
      if (d_inc !== 1'b1) begin
        errors++;
        $display("FAIL score_inc[%0d]: d_inc got %b want 1", i, d_inc);
      end
      if (d_inc === 1'b1) pulses++;
      for (int j = 0; j < 4; j++) begin
        step();
        if (d_inc === 1'b1) pulses++;
      end
    end
    checks++;
    if (pulses != 12) begin
      errors++;
      $display("FAIL score_pulses: got %0d cycles of d_inc want 12", pulses);
    end
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    checks++;
    if ({d_inc, graph_still, balls_left, text_sel} !== {1'b0, 1'b1, 2'd2, 2'd1}) begin
      errors++;
      $display("FAIL hit_and_miss: got inc/still/balls/text %b want %b", {d_inc, graph_still, balls_left, text_sel}, 6'b011001);
    end
  endtask

  task automatic test_newball_delay();
    btn = 2'b01;
    for (int k = 1; k <= TICKS_A; k++) begin
      refr_tick = 1'b1; step(); refr_tick = 1'b0;
      checks++;
      if (graph_still !== 1'b1) begin
        errors++;
        $display("FAIL newball_hold[%0d]: graph_still got %b want 1", k, graph_still);
      end
      step();
      checks++;
      if (k < TICKS_A) begin
        if (graph_still !== 1'b1) begin
          errors++;
          $display("FAIL newball_early[%0d]: graph_still got %b want 1", k, graph_still);
        end
      end else if ({graph_still, d_clr, text_sel} !== {1'b0, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL newball_resume: got still/clr/text %b want 0000", {graph_still, d_clr, text_sel});
      end
    end
    btn = 2'b00;
  endtask

  task automatic test_game_over();
    apply_reset();
    start_game();
    lose_and_resume();
    lose_and_resume();
    checks++;
    if ({graph_still, balls_left} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL over_prep: got still/balls %b want 001", {graph_still, balls_left});
    end
    miss = 1'b1; step(); miss = 1'b0;
    checks++;
    if ({graph_still, game_over, balls_left, text_sel} !== {1'b1, 1'b1, 2'd0, 2'd2}) begin
      errors++;
      $display("FAIL over_enter: got still/over/balls/text %b want 110010", {graph_still, game_over, balls_left, text_sel});
    end
    for (int k = 1; k <= TICKS_A; k++) begin
      refr_tick = 1'b1;
      btn = k[0] ? 2'b01 : 2'b10;
      step();
      refr_tick = 1'b0; btn = 2'b00;
      step();
      checks++;
      if (k < TICKS_A) begin
        if ({game_over, text_sel} !== {1'b1, 2'd2}) begin
          errors++;
          $display("FAIL over_hold[%0d]: got over/text %b want 110", k, {game_over, text_sel});
        end
      end else if ({d_clr, graph_still, game_over, balls_left, text_sel} !== {1'b0, 1'b1, 1'b0, 2'd3, 2'd1}) begin
        errors++;
        $display("FAIL over_exit: got clr/still/over/balls/text %b want 0101101", {d_clr, graph_still, game_over, balls_left, text_sel});
      end
    end
    step();
    checks++;
    if (graph_still !== 1'b1) begin
      errors++;
      $display("FAIL newgame_idle: graph_still got %b want 1", graph_still);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_game();
    lose_and_resume();
    hit = 1'b1; step(); hit = 1'b0;
    btn = 2'b01;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({d_inc, d_clr, graph_still, game_over, balls_left, text_sel} !== {1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1}) begin
      errors++;
      $display("FAIL reset_mid_play: got %b want 00101101", {d_inc, d_clr, graph_still, game_over, balls_left, text_sel});
    end
    step();
    reset = 1'b0;
    step();
    btn = 2'b00;
    checks++;
    if ({d_clr, graph_still, balls_left} !== {1'b1, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL reset_held_btn_start: got clr/still/balls %b want 1011", {d_clr, graph_still, balls_left});
    end
    step();
    lose_and_resume();
    lose_and_resume();
    miss = 1'b1; step(); miss = 1'b0;
    run_ticks(50);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({d_clr, graph_still, game_over, balls_left, text_sel} !== {1'b0, 1'b1, 1'b0, 2'd3, 2'd1}) begin
      errors++;
      $display("FAIL reset_mid_over: got %b want 0101101", {d_clr, graph_still, game_over, balls_left, text_sel});
    end
    step();
    reset = 1'b0;
    step();
    btn = 2'b10; step(); btn = 2'b00;
    checks++;
    if ({d_clr, graph_still, game_over, balls_left} !== {1'b1, 1'b0, 1'b0, 2'd3}) begin
      errors++;
      $display("FAIL restart_after_reset: got clr/still/over/balls %b want 10011", {d_clr, graph_still, game_over, balls_left});
    end
  endtask

  task automatic test_param_corner();
    apply_reset();
    btn_b = 2'b01; step(); btn_b = 2'b00;
    checks++;
    if ({d_clr_b, graph_still_b, balls_left_b} !== {1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL corner_start: got clr/still/balls %b want 1001", {d_clr_b, graph_still_b, balls_left_b});
    end
    miss_b = 1'b1; step(); miss_b = 1'b0;
    checks++;
    if ({game_over_b, balls_left_b, text_sel_b} !== {1'b1, 2'd0, 2'd2}) begin
      errors++;
      $display("FAIL corner_over: got over/balls/text %b want 10010", {game_over_b, balls_left_b, text_sel_b});
    end
    step(); step(); step();
    checks++;
    if (game_over_b !== 1'b1) begin
      errors++;
      $display("FAIL corner_wait: game_over got %b want 1", game_over_b);
    end
    refr_tick_b = 1'b1; step(); refr_tick_b = 1'b0;
    checks++;
    if (game_over_b !== 1'b1) begin
      errors++;
      $display("FAIL corner_tick_edge: game_over got %b want 1", game_over_b);
    end
    step();
    checks++;
    if ({d_clr_b, game_over_b, balls_left_b, text_sel_b} !== {1'b0, 1'b0, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL corner_newgame: got clr/over/balls/text %b want 000101", {d_clr_b, game_over_b, balls_left_b, text_sel_b});
    end
  endtask

  task automatic test_random();
    logic [7:0] got, want;
    apply_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 19) == 0) btn = 2'($urandom_range(0, 3));
      hit = ($urandom_range(0, 9) == 0);
      miss = ($urandom_range(0, 39) == 0);
      refr_tick = ($urandom_range(0, 1) == 1);
      step();
      got = {d_inc, d_clr, graph_still, game_over, balls_left, text_sel};
      want = {m_inc, m_clr, (m_phase != PH_RUN), (m_phase == PH_END), 2'(m_balls),
              (m_phase == PH_RUN) ? 2'd0 : ((m_phase == PH_END) ? 2'd2 : 2'd1)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random[%0d]: inc/clr/still/over/balls/text got %b want %b", c, got, want);
      end
    end
    btn = 0; hit = 0; miss = 0; refr_tick = 0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_scoring();
    test_newball_delay();
    test_game_over();
    test_reset_mid();
    test_param_corner();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
